muldiv_hilo_ctrl: RTL and testbench

Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO that owns the architectural HI/LO registers. Sits beside the execute-stage ALU: ALU handles single-cycle ops and MFHI/MFLO reads HI/LO from this block. Sequences an iterative radix-2 divider and a fixed-latency multiplier, and stalls the pipeline while busy. Honours exception flush from the CP0 path.

---
 rtl/muldiv_pkg.sv | 58 +++++
 rtl/div_radix2_core.sv | 66 ++++++
 rtl/muldiv_hilo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes,
// controller states, default latencies and op classification helpers.
// Optional feature macro: MULDIV_MADD_EN (MADD/MADDU/MSUB/MSUBU accepted).
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int MUL_LAT_DEF  = 2;
  localparam int DIV_ITER_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PRE,
    ST_DIV_ITER,
    ST_DIV_POST
  } state_t;

  // Multiply-accumulate family; only executed when the MAC feature is built in
  function automatic logic is_madd_class(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // Accumulate ops that subtract the product instead of adding it
  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  // Ops that run through the MUL state
  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MADD_EN
    r = r || is_madd_class(op);
`endif
    return r;
  endfunction

  // Ops that run through the divider states
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The first step is taken on the start edge, so ITERS edges produce the result;
// done pulses for one cycle once quotient/remainder are final.
module div_radix2_core #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CW = $clog2(ITERS + 1);

  logic [CW-1:0] count;
  logic [31:0]   divisor_q;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  function automatic logic [63:0] div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dsr);
    logic [32:0] shifted;
    logic [32:0] trial;
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dsr};
    if (!trial[32]) return {trial[31:0], quo[30:0], 1'b1};
    return {shifted[31:0], quo[30:0], 1'b0};
  endfunction

  // Step sequencer: load and first step on start, then one step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      divisor_q <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        busy  <= 1'b0;
        count <= '0;
      end else if (start && !busy) begin
        {remainder, quotient} <= div_step(32'd0, dividend, divisor);
        divisor_q <= divisor;
        count     <= CW'(ITERS - 1);
        busy      <= 1'b1;
      end else if (busy) begin
        {remainder, quotient} <= div_step(remainder, quotient, divisor_q);
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO beside the execute-stage ALU.
// Sequences a fixed-latency multiplier and the radix-2 divider core, applies
// divide sign fixup, and stalls the pipeline while an op is in flight.
// Optional feature macro: MULDIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  state_t      state;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  cnt;
  logic        q_neg;
  logic        r_neg;

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;
  logic [63:0] mul_result;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  assign signed_op = is_signed_op(op_q);
  assign a_ext     = {{32{signed_op & a_q[31]}}, a_q};
  assign b_ext     = {{32{signed_op & b_q[31]}}, b_q};
  assign product   = a_ext * b_ext;
  assign a_abs     = (signed_op && a_q[31]) ? -a_q : a_q;
  assign b_abs     = (signed_op && b_q[31]) ? -b_q : b_q;
  assign div_start = (state == ST_DIV_PRE) && !flush_i && !div_busy;

  div_radix2_core #(
    .ITERS(DIV_ITER)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .flush    (flush_i),
    .dividend (a_abs),
    .divisor  (b_abs),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot),
    .remainder(div_rem)
  );

  // Value written to {HI,LO} when the multiply finishes (plain or accumulate)
  always_comb begin
    mul_result = product;
`ifdef MULDIV_MADD_EN
    if (is_madd_class(op_q)) begin
      if (is_sub_op(op_q)) mul_result = {hi_o, lo_o} - product;
      else                 mul_result = {hi_o, lo_o} + product;
    end
`endif
  end

  // Divide result after sign fixup; a zero divisor yields all-ones / dividend
  always_comb begin
    div_lo = q_neg ? -div_quot : div_quot;
    div_hi = r_neg ? -div_rem : div_rem;
    if (b_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end
  end

  // Pipeline hold: busy, or a long op being requested; a flush always releases it
  always_comb begin
    stall_o = 1'b0;
    if (!flush_i) begin
      stall_o = (state != ST_IDLE) ||
                (start_i && (is_mul_op(op_i) || is_div_op(op_i)));
    end
  end

  // Controller FSM owning HI/LO; reset beats flush, flush beats start
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (op_i == OP_MTHI) begin
                hi_o   <= a_i;
                done_o <= 1'b1;
              end else if (op_i == OP_MTLO) begin
                lo_o   <= a_i;
                done_o <= 1'b1;
              end else if (is_mul_op(op_i)) begin
                op_q  <= op_i;
                a_q   <= a_i;
                b_q   <= b_i;
                cnt   <= 3'(MUL_LAT - 1);
                state <= ST_MUL;
              end else if (is_div_op(op_i)) begin
                op_q  <= op_i;
                a_q   <= a_i;
                b_q   <= b_i;
                state <= ST_DIV_PRE;
              end
            end
          end
          ST_MUL: begin
            if (cnt == 3'd0) begin
              {hi_o, lo_o} <= mul_result;
              done_o       <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          ST_DIV_PRE: begin
            if (!div_busy) begin
              q_neg <= signed_op & (a_q[31] ^ b_q[31]);
              r_neg <= signed_op & a_q[31];
              state <= ST_DIV_ITER;
            end
          end
          ST_DIV_ITER: begin
            if (div_done) state <= ST_DIV_POST;
          end
          ST_DIV_POST: begin
            hi_o   <= div_hi;
            lo_o   <= div_lo;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed corner cases followed by
// random ops, compared against an arithmetic model of HI/LO and op latency.
`timescale 1ns/1ps
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  muldiv_hilo_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_ITER(32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .op_i   (op_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .flush_i(flush_i),
    .stall_o(stall_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Architectural model: updates mhi/mlo and reports expected latency
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic valid, output logic long_op, output int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    valid = 1'b1;
    long_op = 1'b1;
    lat = 0;
    case (op)
      OP_MTHI: begin long_op = 1'b0; mhi = a; end
      OP_MTLO: begin long_op = 1'b0; mlo = a; end
      OP_MULT: begin lat = MUL_LAT; {mhi, mlo} = 64'(sa * sb); end
      OP_MULTU: begin lat = MUL_LAT; {mhi, mlo} = {32'd0, a} * {32'd0, b}; end
      OP_DIV: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mlo = 32'h8000_0000; mhi = 32'd0; end
        else begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (b == 32'd0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
        else begin mlo = a / b; mhi = a % b; end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin lat = MUL_LAT; {mhi, mlo} = {mhi, mlo} + 64'(sa * sb); end
      OP_MADDU: begin lat = MUL_LAT; {mhi, mlo} = {mhi, mlo} + {32'd0, a} * {32'd0, b}; end
      OP_MSUB:  begin lat = MUL_LAT; {mhi, mlo} = {mhi, mlo} - 64'(sa * sb); end
      OP_MSUBU: begin lat = MUL_LAT; {mhi, mlo} = {mhi, mlo} - {32'd0, a} * {32'd0, b}; end
`endif
      default: begin valid = 1'b0; long_op = 1'b0; end
    endcase
  endtask

  // Issue one op, poke a spurious start while busy, then check timing and HI/LO
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    logic valid;
    logic long_op;
    int   lat;
    int   done_cyc;
    int   stall_cnt;
    int   k;
    modelOp(op, a, b, valid, long_op, lat);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1 checkOutput({tag, ":stall_start"}, 64'(stall_o), 64'(long_op));
    tick(1);
    if (long_op) begin
      op_i = OP_MTHI; a_i = $urandom; b_i = $urandom;
    end else begin
      start_i = 1'b0;
    end
    done_cyc = -1; stall_cnt = 0; k = 1;
    while (done_cyc < 0 && k <= 45) begin
      if (done_o) done_cyc = k;
      else begin
        if (stall_o) stall_cnt++;
        tick(1);
        start_i = 1'b0;
        k++;
      end
    end
    start_i = 1'b0;
    checkOutput({tag, ":done_cycle"}, 64'(done_cyc), valid ? 64'(lat + 1) : 64'(-1));
    checkOutput({tag, ":stall_cycles"}, 64'(stall_cnt), 64'(lat));
    checkOutput({tag, ":hi"}, 64'(hi_o), 64'(mhi));
    checkOutput({tag, ":lo"}, 64'(lo_o), 64'(mlo));
    if (valid) begin
      checkOutput({tag, ":stall_at_done"}, 64'(stall_o), 64'd0);
      tick(1);
      checkOutput({tag, ":done_single"}, 64'(done_o), 64'd0);
    end
  endtask

  // Count done pulses over a window with no new requests
  task automatic countDone(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      if (done_o) pulses++;
      tick(1);
    end
  endtask

  initial begin
    int pulses;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
    tick(3);
    rst = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset:hi", 64'(hi_o), 64'd0);
    checkOutput("reset:lo", 64'(lo_o), 64'd0);
    checkOutput("reset:done", 64'(done_o), 64'd0);
    checkOutput("reset:stall", 64'(stall_o), 64'd0);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    checkOutput("mult_neg:hi_const", 64'(hi_o), 64'hFFFF_FFFF);
    checkOutput("mult_neg:lo_const", 64'(lo_o), 64'hFFFF_FFF1);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    checkOutput("multu:hi_const", 64'(hi_o), 64'h0000_0004);
    checkOutput("multu:lo_const", 64'(lo_o), 64'hFFFF_FFF1);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    checkOutput("divu_100_7:lo_const", 64'(lo_o), 64'h0000_000E);
    checkOutput("divu_100_7:hi_const", 64'(hi_o), 64'h0000_0002);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    checkOutput("div_m7_2:lo_const", 64'(lo_o), 64'hFFFF_FFFD);
    checkOutput("div_m7_2:hi_const", 64'(hi_o), 64'hFFFF_FFFF);
    applyStimulus(OP_DIV, 32'h1234_5678, 32'd0, "div_by_zero");
    checkOutput("div_by_zero:lo_const", 64'(lo_o), 64'hFFFF_FFFF);
    checkOutput("div_by_zero:hi_const", 64'(hi_o), 64'h1234_5678);
    applyStimulus(OP_DIVU, 32'h8765_4321, 32'd0, "divu_by_zero");
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checkOutput("div_ovf:lo_const", 64'(lo_o), 64'h8000_0000);
    checkOutput("div_ovf:hi_const", 64'(hi_o), 64'h0);

    // MTHI then MTLO on consecutive cycles
    start_i = 1'b1; op_i = OP_MTHI; a_i = 32'hDEAD_BEEF; b_i = '0;
    #1 checkOutput("mthi_b2b:stall", 64'(stall_o), 64'd0);
    tick(1);
    op_i = OP_MTLO; a_i = 32'h1;
    #1 checkOutput("mtlo_b2b:stall", 64'(stall_o), 64'd0);
    checkOutput("mthi_b2b:done", 64'(done_o), 64'd1);
    tick(1);
    start_i = 1'b0;
    mhi = 32'hDEAD_BEEF; mlo = 32'h1;
    checkOutput("mtlo_b2b:done", 64'(done_o), 64'd1);
    checkOutput("mthi_b2b:hi", 64'(hi_o), 64'hDEAD_BEEF);
    checkOutput("mtlo_b2b:lo", 64'(lo_o), 64'h1);
    tick(1);

    // Flush during divide iterations
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3;
    tick(1);
    start_i = 1'b0;
    tick(10);
    flush_i = 1'b1;
    #1 checkOutput("flush_div:stall_during", 64'(stall_o), 64'd0);
    tick(1);
    flush_i = 1'b0;
    #1 checkOutput("flush_div:stall_after", 64'(stall_o), 64'd0);
    countDone(40, pulses);
    checkOutput("flush_div:done_pulses", 64'(pulses), 64'd0);
    checkOutput("flush_div:hi", 64'(hi_o), 64'(mhi));
    checkOutput("flush_div:lo", 64'(lo_o), 64'(mlo));

    // Flush on the final multiply cycle suppresses the write
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd9; b_i = 32'd9;
    tick(1);
    start_i = 1'b0;
    tick(1);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    countDone(5, pulses);
    checkOutput("flush_mul_last:done_pulses", 64'(pulses), 64'd0);
    checkOutput("flush_mul_last:lo", 64'(lo_o), 64'(mlo));

    // Flush together with an MTLO request in IDLE
    start_i = 1'b1; op_i = OP_MTLO; a_i = 32'hCAFE_0000; flush_i = 1'b1;
    tick(1);
    start_i = 1'b0; flush_i = 1'b0;
    checkOutput("flush_mtlo:done", 64'(done_o), 64'd0);
    checkOutput("flush_mtlo:lo", 64'(lo_o), 64'(mlo));

    // Undefined op codes do nothing
    applyStimulus(4'hF, 32'h1111_1111, 32'h2222_2222, "undef_f");
`ifndef MULDIV_MADD_EN
    applyStimulus(OP_MADD, 32'd3, 32'd4, "madd_disabled");
`endif

`ifdef MULDIV_MADD_EN
    applyStimulus(OP_MTHI, 32'd0, 32'd0, "madd_pre_hi");
    applyStimulus(OP_MTLO, 32'h10, 32'd0, "madd_pre_lo");
    applyStimulus(OP_MADD, 32'd3, 32'd4, "madd");
    checkOutput("madd:lo_const", 64'(lo_o), 64'h1C);
    applyStimulus(OP_MSUBU, 32'd1, 32'h1D, "msubu");
    checkOutput("msubu:hilo_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

    // Reset in the middle of a divide clears HI/LO and cancels the op
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'd77; b_i = 32'd5;
    tick(1);
    start_i = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mhi = '0; mlo = '0;
    checkOutput("rst_mid_div:hi", 64'(hi_o), 64'd0);
    checkOutput("rst_mid_div:lo", 64'(lo_o), 64'd0);
    checkOutput("rst_mid_div:stall", 64'(stall_o), 64'd0);
    countDone(40, pulses);
    checkOutput("rst_mid_div:done_pulses", 64'(pulses), 64'd0);

    // Random ops, including undefined codes and divide corner operands
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = $urandom_range(0, 10);
      rop = (sel == 10) ? 4'hE : 4'(sel);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'($urandom_range(0, 1000)); rb = -32'($urandom_range(1, 20)); end
        default: ;
      endcase
      applyStimulus(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
